// File: rtl/lab1_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lab1_pkg
//  Description : Shared FSM encoding, sweep size and result-vector bit map
//                for the Lab1 gate self-test sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package lab1_pkg;

   localparam int NUM_VEC = 8;
   localparam int RES_W   = 5;

   // Bit positions in the 5-bit result vector {not_a,nor,nand,or,and}
   localparam int RES_AND   = 0;
   localparam int RES_OR    = 1;
   localparam int RES_NAND  = 2;
   localparam int RES_NOR   = 3;
   localparam int RES_NOT_A = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage : lab1_pkg
`default_nettype wire

// File: rtl/lab1_gate_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : lab1_gate_sequencer_if
//  Description : Link between the sequencer and the gate block under test.
//  Revision    : 1.0  initial release
// ============================================================================
interface lab1_gate_sequencer_if;

   logic gate_a;
   logic gate_b;
   logic gate_c;
   logic and_in;
   logic or_in;
   logic nand_in;
   logic nor_in;
   logic not_a_in;

   // master = sequencer, slave = gate block
   modport master (
      output gate_a, gate_b, gate_c,
      input  and_in, or_in, nand_in, nor_in, not_a_in
   );

   modport slave (
      input  gate_a, gate_b, gate_c,
      output and_in, or_in, nand_in, nor_in, not_a_in
   );

endinterface : lab1_gate_sequencer_if
`default_nettype wire

// File: rtl/lab1_gate_model.sv
`default_nettype none
// ============================================================================
//  Module      : lab1_gate_model
//  Description : Combinational golden model of the Lab1 gate block.
//  Revision    : 1.0  initial release
// ============================================================================
module lab1_gate_model
   import lab1_pkg::*;
(
   input  wire logic             a,
   input  wire logic             b,
   input  wire logic             c,
   output      logic [RES_W-1:0] expected
);

   always_comb begin
      expected            = '0;
      expected[RES_AND]   = a & b & c;
      expected[RES_OR]    = a | b | c;
      expected[RES_NAND]  = ~(a & b & c);
      expected[RES_NOR]   = ~(a | b | c);
      expected[RES_NOT_A] = ~a;
   end

endmodule : lab1_gate_model
`default_nettype wire

// File: rtl/lab1_gate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lab1_gate_sequencer
//  Description : Sweeps all 8 {a,b,c} vectors into the gate block, compares
//                the sampled outputs with a golden model, reports results.
//  Revision    : 1.0  initial release
// ============================================================================
module lab1_gate_sequencer
   import lab1_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [4:0] CHECK_MASK    = 5'h1F
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   input  wire logic            start,
   input  wire logic            abort,
   lab1_gate_sequencer_if.master gate,
   output      logic            busy,
   output      logic            done,
   output      logic            pass,
   output      logic [3:0]      err_count,
   output      logic [2:0]      fail_vec,
   output      logic            fail_valid
);

   state_t           r_state;
   state_t           w_nextState;
   logic [2:0]       r_vec;
   logic [3:0]       r_settle;
   logic             r_done;
   logic             r_pass;
   logic [3:0]       r_errCount;
   logic [2:0]       r_failVec;
   logic             r_failValid;

   logic             w_busy;
   logic             w_accept;
   logic             w_abortSweep;
   logic             w_settleDone;
   logic             w_lastVec;
   logic             w_mismatch;
   logic [3:0]       w_errNext;
   logic [RES_W-1:0] w_expected;
   logic [RES_W-1:0] w_observed;

   lab1_gate_model u_model (
      .a        (r_vec[2]),
      .b        (r_vec[1]),
      .c        (r_vec[0]),
      .expected (w_expected)
   );

   always_comb begin
      w_observed            = '0;
      w_observed[RES_AND]   = gate.and_in;
      w_observed[RES_OR]    = gate.or_in;
      w_observed[RES_NAND]  = gate.nand_in;
      w_observed[RES_NOR]   = gate.nor_in;
      w_observed[RES_NOT_A] = gate.not_a_in;
   end

   assign w_busy       = (r_state == DRIVE) || (r_state == SAMPLE);
   assign w_accept     = !w_busy && start && !abort;
   assign w_abortSweep = w_busy && abort;
   assign w_settleDone = (r_settle == 4'(SETTLE_CYCLES - 1));
   assign w_lastVec    = (r_vec == 3'(NUM_VEC - 1));
   assign w_mismatch   = |((w_observed ^ w_expected) & CHECK_MASK);
   assign w_errNext    = r_errCount + {3'd0, w_mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = DRIVE;
         DRIVE: begin
            if (abort)             w_nextState = IDLE;
            else if (w_settleDone) w_nextState = SAMPLE;
         end
         SAMPLE: begin
            if (abort)          w_nextState = IDLE;
            else if (w_lastVec) w_nextState = DONE;
            else                w_nextState = DRIVE;
         end
         DONE:    if (w_accept) w_nextState = DRIVE;
         default: w_nextState = IDLE;
      endcase
   end

   // A new sweep and an abort both wipe every result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec       <= '0;
         r_settle    <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_errCount  <= '0;
         r_failVec   <= '0;
         r_failValid <= 1'b0;
      end else if (w_accept || w_abortSweep) begin
         r_vec       <= '0;
         r_settle    <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_errCount  <= '0;
         r_failVec   <= '0;
         r_failValid <= 1'b0;
      end else if (r_state == DRIVE) begin
         r_settle <= r_settle + 4'd1;
      end else if (r_state == SAMPLE) begin
         r_errCount <= w_errNext;
         if (w_mismatch && !r_failValid) begin
            r_failVec   <= r_vec;
            r_failValid <= 1'b1;
         end
         if (w_lastVec) begin
            r_done <= 1'b1;
            r_pass <= (w_errNext == 4'd0);
            r_vec  <= '0;
         end else begin
            r_vec <= r_vec + 3'd1;
         end
         r_settle <= '0;
      end
   end

   assign gate.gate_a = w_busy & r_vec[2];
   assign gate.gate_b = w_busy & r_vec[1];
   assign gate.gate_c = w_busy & r_vec[0];

   assign busy       = w_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_count  = r_errCount;
   assign fail_vec   = r_failVec;
   assign fail_valid = r_failValid;

endmodule : lab1_gate_sequencer
`default_nettype wire

// File: tb/tb_lab1_gate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lab1_gate_sequencer
//  Description : Directed self-checking bench; DUT0 full mask, DUT1 mask 1E.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lab1_gate_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       fAnd0;
   logic       fNotA1;

   logic       busy0, done0, pass0, failValid0;
   logic [3:0] errCount0;
   logic [2:0] failVec0;
   logic       busy1, done1, pass1, failValid1;
   logic [3:0] errCount1;
   logic [2:0] failVec1;

   int nChecks = 0;
   int nPass   = 0;
   int dc;

   lab1_gate_sequencer_if gIf0 ();
   lab1_gate_sequencer_if gIf1 ();

   lab1_gate_sequencer #(.SETTLE_CYCLES(2), .CHECK_MASK(5'h1F)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate(gIf0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(errCount0),
      .fail_vec(failVec0), .fail_valid(failValid0)
   );

   lab1_gate_sequencer #(.SETTLE_CYCLES(2), .CHECK_MASK(5'h1E)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate(gIf1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(errCount1),
      .fail_vec(failVec1), .fail_valid(failValid1)
   );

   // Gate block under test, with injectable stuck-at faults
   always_comb begin
      gIf0.and_in   = fAnd0 ? 1'b0 : (gIf0.gate_a & gIf0.gate_b & gIf0.gate_c);
      gIf0.or_in    = gIf0.gate_a | gIf0.gate_b | gIf0.gate_c;
      gIf0.nand_in  = ~(gIf0.gate_a & gIf0.gate_b & gIf0.gate_c);
      gIf0.nor_in   = ~(gIf0.gate_a | gIf0.gate_b | gIf0.gate_c);
      gIf0.not_a_in = fNotA1 ? 1'b1 : ~gIf0.gate_a;
   end

   always_comb begin
      gIf1.and_in   = fAnd0 ? 1'b0 : (gIf1.gate_a & gIf1.gate_b & gIf1.gate_c);
      gIf1.or_in    = gIf1.gate_a | gIf1.gate_b | gIf1.gate_c;
      gIf1.nand_in  = ~(gIf1.gate_a & gIf1.gate_b & gIf1.gate_c);
      gIf1.nor_in   = ~(gIf1.gate_a | gIf1.gate_b | gIf1.gate_c);
      gIf1.not_a_in = fNotA1 ? 1'b1 : ~gIf1.gate_a;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Pulses start, returns the cycle (after the start edge) where done0 first rises, -1 on timeout
   task automatic runSweep(input bit checkGates, input int extraStartAt, output int doneCycle);
      doneCycle = -1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i <= 40; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         start = (extraStartAt == i);
         if (checkGates && i < 24)
            checkEq($sformatf("gateVec%0d", i), {gIf0.gate_a, gIf0.gate_b, gIf0.gate_c}, i / 3);
         if (done0 && doneCycle < 0) begin
            doneCycle = i;
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      fAnd0  = 1'b0;
      fNotA1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkEq("rstOutputs", {busy0, done0, pass0, errCount0, failVec0, failValid0}, 0);
      checkEq("rstGates", {gIf0.gate_a, gIf0.gate_b, gIf0.gate_c}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Good block
      runSweep(1'b1, -1, dc);
      checkEq("goodDoneCycle", dc, 24);
      checkEq("goodPass", pass0, 1);
      checkEq("goodErr", errCount0, 0);
      checkEq("goodFailValid", failValid0, 0);
      checkEq("goodBusy", busy0, 0);
      checkEq("goodGatesIdle", {gIf0.gate_a, gIf0.gate_b, gIf0.gate_c}, 0);
      checkEq("goodPassMasked", pass1, 1);

      // and_in stuck at 0: only vector 111 fails; masked DUT ignores it
      fAnd0 = 1'b1;
      runSweep(1'b0, -1, dc);
      checkEq("and0DoneCycle", dc, 24);
      checkEq("and0Err", errCount0, 1);
      checkEq("and0FailVec", failVec0, 3'b111);
      checkEq("and0FailValid", failValid0, 1);
      checkEq("and0Pass", pass0, 0);
      checkEq("maskPass", pass1, 1);
      checkEq("maskErr", errCount1, 0);
      checkEq("maskDone", done1, 1);
      fAnd0 = 1'b0;

      // not_a_in stuck at 1: vectors 100..111 fail
      fNotA1 = 1'b1;
      runSweep(1'b0, -1, dc);
      checkEq("notA1Err", errCount0, 4);
      checkEq("notA1FailVec", failVec0, 3'b100);
      checkEq("notA1FailValid", failValid0, 1);
      checkEq("notA1Pass", pass0, 0);
      fNotA1 = 1'b0;

      // Abort during vector 3 (cycles 9..11 after the start edge)
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkEq("restartClearsDone", done0, 0);
      repeat (9) @(posedge clk);
      #1;
      checkEq("abortPreVec", {gIf0.gate_a, gIf0.gate_b, gIf0.gate_c}, 3);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkEq("abortBusy", busy0, 0);
      checkEq("abortDone", done0, 0);
      checkEq("abortGates", {gIf0.gate_a, gIf0.gate_b, gIf0.gate_c}, 0);
      checkEq("abortErr", {errCount0, failValid0}, 0);
      repeat (3) @(posedge clk);
      #1;
      checkEq("abortStaysIdle", {busy0, done0}, 0);
      runSweep(1'b0, -1, dc);
      checkEq("postAbortDoneCycle", dc, 24);
      checkEq("postAbortPass", pass0, 1);

      // Reset mid-sweep with a failure already recorded
      fNotA1 = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      checkEq("preRstErr", {errCount0, failValid0}, {4'd1, 1'b1});
      #2;
      rst_n = 1'b0;
      #1;
      checkEq("midRstOutputs", {busy0, done0, pass0, errCount0, failVec0, failValid0}, 0);
      checkEq("midRstGates", {gIf0.gate_a, gIf0.gate_b, gIf0.gate_c}, 0);
      fNotA1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      runSweep(1'b0, 6, dc);
      checkEq("extraStartDoneCycle", dc, 24);
      checkEq("extraStartPass", pass0, 1);
      checkEq("extraStartErr", errCount0, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule : tb_lab1_gate_sequencer
`default_nettype wire
